// File: rtl/sm4_pkg.sv
// rtl/sm4_pkg.sv - SM4 constants, linear transforms and FSM state type
// Purpose: shared definitions for the iterative SM4 decryptor.
// Contents: FK/CK key-schedule constants, rotl32/sm4_l/sm4_lp, sm4_state_e.
package sm4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } sm4_state_e;

  localparam logic [31:0] FK [4] = '{
    32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc
  };

  localparam logic [31:0] CK [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Data-path linear transform L
  function automatic logic [31:0] sm4_l(input logic [31:0] b);
    return b ^ rotl32(b, 2) ^ rotl32(b, 10) ^ rotl32(b, 18) ^ rotl32(b, 24);
  endfunction

  // Key-schedule linear transform L'
  function automatic logic [31:0] sm4_lp(input logic [31:0] b);
    return b ^ rotl32(b, 13) ^ rotl32(b, 23);
  endfunction

endpackage

// File: rtl/sm4_de_iter_if.sv
// rtl/sm4_de_iter_if.sv - block in/out handshake bundle for sm4_de_iter
// Purpose: groups the request (ciphertext + key) and response (plaintext) handshakes.
// Signals: in_valid/in_ready/data_in/key (request), out_valid/out_ready/data_out (response).
// Modports: master = block source/sink (bench or upstream), slave = decryptor.
interface sm4_de_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  modport master (
    output in_valid, data_in, key, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, key, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/sbox.sv
// rtl/sbox.sv - SM4 byte substitution (tau), NUM bytes in parallel
// Purpose: combinational SM4 S-box applied independently to each byte.
// Ports: din_i [8*NUM-1:0] input bytes, dout_o [8*NUM-1:0] substituted bytes.
module sbox #(
  parameter int NUM = 4
) (
  input  logic [8*NUM-1:0] din_i,
  output logic [8*NUM-1:0] dout_o
);

  // Entry 0x00 occupies the top byte; entry b lives at bit offset (255-b)*8 = {~b,3'b000}.
  localparam logic [2047:0] TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  for (genvar g = 0; g < NUM; g++) begin : g_byte
    assign dout_o[8*g +: 8] = TABLE[{~din_i[8*g +: 8], 3'b000} +: 8];
  end

endmodule

// File: rtl/sm4_round_f.sv
// rtl/sm4_round_f.sv - one SM4 round/key-schedule step with shared S-box
// Purpose: y = x0 ^ L(tau(x1^x2^x3^rk)), or L' instead of L in key mode.
// Ports: x0_i..x3_i window words, rk_i round key or CK, key_mode_i selects L', y_o new word.
module sm4_round_f
  import sm4_pkg::*;
(
  input  logic [31:0] x0_i,
  input  logic [31:0] x1_i,
  input  logic [31:0] x2_i,
  input  logic [31:0] x3_i,
  input  logic [31:0] rk_i,
  input  logic        key_mode_i,
  output logic [31:0] y_o
);

  logic [31:0] mix;
  logic [31:0] sub;

  assign mix = x1_i ^ x2_i ^ x3_i ^ rk_i;

  sbox #(.NUM(4)) u_sbox (
    .din_i  (mix),
    .dout_o (sub)
  );

  assign y_o = x0_i ^ (key_mode_i ? sm4_lp(sub) : sm4_l(sub));

endmodule

// File: rtl/sm4_de_iter.sv
// rtl/sm4_de_iter.sv - iterative SM4 block decryptor, one round per clock
// Purpose: accepts ciphertext+key, expands round keys serially (skipped on a key-cache
//          hit when KEY_CACHE=1), runs 32 rounds with the keys reversed, returns plaintext.
// Ports: clk, rst (async, active-high), bus (sm4_de_iter_if.slave handshake bundle).
module sm4_de_iter
  import sm4_pkg::*;
#(
  parameter int KEY_CACHE = 1
) (
  input logic          clk,
  input logic          rst,
  sm4_de_iter_if.slave bus
);

  sm4_state_e   state_q;
  logic [4:0]   cnt_q;
  logic [31:0]  x_q [4];
  logic [31:0]  k_q [4];
  logic [31:0]  rk_q [32];
  logic [127:0] key_q;
  logic         cache_valid_q;
  logic [127:0] data_out_q;
  logic         out_valid_q;

  logic         accept;
  logic         cache_hit;
  logic         key_mode;
  logic [31:0]  f_x0, f_x1, f_x2, f_x3, f_rk;
  logic [31:0]  word_d;

  // Held low during reset even though the state register already reads IDLE.
  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;

  assign accept    = (state_q == ST_IDLE) && bus.in_valid;
  // key_q still holds the previous block's key at the accept edge.
  assign cache_hit = (KEY_CACHE != 0) && cache_valid_q && (bus.key == key_q);

  // The single round function serves the key schedule (K window, CK) or the
  // data rounds (X window, rk in reverse); the two phases never overlap.
  always_comb begin
    key_mode = (state_q == ST_KEYEXP);
    if (key_mode) begin
      f_x0 = k_q[0];
      f_x1 = k_q[1];
      f_x2 = k_q[2];
      f_x3 = k_q[3];
      f_rk = CK[cnt_q];
    end else begin
      f_x0 = x_q[0];
      f_x1 = x_q[1];
      f_x2 = x_q[2];
      f_x3 = x_q[3];
      f_rk = rk_q[cnt_q];
    end
  end

  sm4_round_f u_round (
    .x0_i       (f_x0),
    .x1_i       (f_x1),
    .x2_i       (f_x2),
    .x3_i       (f_x3),
    .rk_i       (f_rk),
    .key_mode_i (key_mode),
    .y_o        (word_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      key_q         <= '0;
      cache_valid_q <= 1'b0;
      data_out_q    <= '0;
      out_valid_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= '0;
        k_q[i] <= '0;
      end
      for (int i = 0; i < 32; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            x_q[0] <= bus.data_in[127:96];
            x_q[1] <= bus.data_in[95:64];
            x_q[2] <= bus.data_in[63:32];
            x_q[3] <= bus.data_in[31:0];
            k_q[0] <= bus.key[127:96] ^ FK[0];
            k_q[1] <= bus.key[95:64]  ^ FK[1];
            k_q[2] <= bus.key[63:32]  ^ FK[2];
            k_q[3] <= bus.key[31:0]   ^ FK[3];
            key_q  <= bus.key;
            if (cache_hit) begin
              state_q <= ST_ROUND;
              cnt_q   <= 5'd31;
            end else begin
              // rk store is about to be overwritten; it no longer matches any key.
              state_q       <= ST_KEYEXP;
              cnt_q         <= 5'd0;
              cache_valid_q <= 1'b0;
            end
          end
        end
        ST_KEYEXP: begin
          rk_q[cnt_q] <= word_d;
          k_q[0]      <= k_q[1];
          k_q[1]      <= k_q[2];
          k_q[2]      <= k_q[3];
          k_q[3]      <= word_d;
          if (cnt_q == 5'd31) begin
            cache_valid_q <= 1'b1;
            state_q       <= ST_ROUND;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        ST_ROUND: begin
          x_q[0] <= x_q[1];
          x_q[1] <= x_q[2];
          x_q[2] <= x_q[3];
          x_q[3] <= word_d;
          if (cnt_q == 5'd0) begin
            // Window is X31..X34 and word_d is X35; output is the reversed last four.
            data_out_q  <= {word_d, x_q[3], x_q[2], x_q[1]};
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_de_iter.sv
// tb/tb_sm4_de_iter.sv - directed self-checking bench for sm4_de_iter
// Drives a cached (KEY_CACHE=1) and an uncached (KEY_CACHE=0) instance through one bench-side handshake.
module tb_sm4_de_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cur = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] data_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sm4_de_iter_if bus_c ();
  sm4_de_iter_if bus_n ();

  assign bus_c.in_valid  = (cur == 1'b0) && in_valid;
  assign bus_n.in_valid  = (cur == 1'b1) && in_valid;
  assign bus_c.out_ready = (cur == 1'b0) && out_ready;
  assign bus_n.out_ready = (cur == 1'b1) && out_ready;
  assign bus_c.data_in   = data_in;
  assign bus_n.data_in   = data_in;
  assign bus_c.key       = key;
  assign bus_n.key       = key;
  assign in_ready  = cur ? bus_n.in_ready  : bus_c.in_ready;
  assign out_valid = cur ? bus_n.out_valid : bus_c.out_valid;
  assign data_out  = cur ? bus_n.data_out  : bus_c.data_out;

  sm4_de_iter #(.KEY_CACHE(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));
  sm4_de_iter #(.KEY_CACHE(0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_CT  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] KEY2    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT2     = 128'hffeeddccbbaa99887766554433221100;

  localparam logic [2047:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [31:0] m_rol(input logic [31:0] a, input int n);
    return (a << n) | (a >> (32 - n));
  endfunction

  function automatic logic [31:0] m_tau(input logic [31:0] a);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) begin
      int idx;
      idx = int'(a[8*j +: 8]);
      r[8*j +: 8] = SB[(255 - idx) * 8 +: 8];
    end
    return r;
  endfunction

  // Forward (encrypt) reference, independent of the decryptor's reverse-key datapath.
  function automatic logic [127:0] m_encrypt(input logic [127:0] p, input logic [127:0] k);
    logic [31:0] kk [36];
    logic [31:0] xx [36];
    logic [31:0] rk [32];
    logic [31:0] fk [4];
    logic [31:0] ck;
    logic [31:0] b;
    fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
    for (int i = 0; i < 4; i++) begin
      kk[i] = k[127 - 32*i -: 32] ^ fk[i];
      xx[i] = p[127 - 32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      b = m_tau(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck);
      rk[i] = kk[i] ^ b ^ m_rol(b, 13) ^ m_rol(b, 23);
      kk[i+4] = rk[i];
    end
    for (int i = 0; i < 32; i++) begin
      b = m_tau(xx[i+1] ^ xx[i+2] ^ xx[i+3] ^ rk[i]);
      xx[i+4] = xx[i] ^ b ^ m_rol(b, 2) ^ m_rol(b, 10) ^ m_rol(b, 18) ^ m_rol(b, 24);
    end
    return {xx[35], xx[34], xx[33], xx[32]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One block: accept, measure accept-to-out_valid edges, optional DONE stall, then handshake.
  task automatic run_block(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p,
                           input int exp_lat, input int stall, input bit poke, input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    data_in  = c;
    key      = k;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = '0;
    key      = '0;
    for (int n = 1; n <= 200 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = n;
      if (poke && (n == 5 || n == 20)) begin
        in_valid = 1'b1;
        data_in  = {$urandom, $urandom, $urandom, $urandom};
        key      = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_data_out"}, data_out, p);
    chk({tag, "_in_ready_done"}, 128'(in_ready), 128'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, 128'(out_valid), 128'd1);
      chk({tag, "_stall_data"}, data_out, p);
      chk({tag, "_stall_in_ready"}, 128'(in_ready), 128'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_out_valid_clr"}, 128'(out_valid), 128'd0);
    chk({tag, "_in_ready_back"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] ct2;
    ct2 = m_encrypt(PT2, KEY2);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_data_out", data_out, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    run_block(STD_CT, STD_KEY, STD_KEY, 64, 0, 1'b0, "std");
    run_block(STD_CT, STD_KEY, STD_KEY, 32, 0, 1'b0, "std_hit");
    run_block(ct2, KEY2, PT2, 64, 0, 1'b0, "key2_miss");
    run_block(STD_CT, STD_KEY, STD_KEY, 64, 0, 1'b0, "std_miss");
    run_block(STD_CT, STD_KEY, STD_KEY, 32, 10, 1'b0, "stall");
    run_block(ct2, KEY2, PT2, 64, 0, 1'b1, "poke_miss");
    run_block(ct2, KEY2, PT2, 32, 0, 1'b1, "poke_hit");

    // Reset while ROUND is at cnt=15 (48 edges after a missing accept).
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = STD_CT;
    key      = STD_KEY;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_data_out", data_out, 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_after", 128'(in_ready), 128'd1);
    chk("midrst_out_valid_after", 128'(out_valid), 128'd0);
    run_block(STD_CT, STD_KEY, STD_KEY, 64, 0, 1'b0, "after_rst");

    cur = 1'b1;
    run_block(STD_CT, STD_KEY, STD_KEY, 64, 0, 1'b0, "nocache_1");
    run_block(STD_CT, STD_KEY, STD_KEY, 64, 0, 1'b0, "nocache_2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
